branch_resolver: RTL and testbench

Execute-stage companion to the 2-bit branch predictor. It carries each fetched branch's prediction and both candidate PCs from ID into EX, and compares the prediction with the actual outcome when the branch executes. On a misprediction it issues a one-cycle flush and PC redirect. It drives the predictor's training inputs (`branch_i`, `update_i`) and keeps saturating branch and mispredict counters.

---
 rtl/branch_resolver.sv | 99 +++++++++
 tb/tb_branch_resolver.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// EX-stage branch resolver: carries the ID branch's prediction and both candidate
// PCs into EX, detects mispredictions, flushes/redirects and trains the predictor.
module branch_resolver #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              stall_i,
   input  logic              id_branch_i,
   input  logic              id_predict_i,
   input  logic [ADDR_W-1:0] id_target_i,
   input  logic [ADDR_W-1:0] id_fallthru_i,
   input  logic              ex_taken_i,
   output logic              branch_o,
   output logic              update_o,
   output logic              flush_o,
   output logic              redirect_valid_o,
   output logic [ADDR_W-1:0] redirect_pc_o,
   output logic [CNT_W-1:0]  branch_cnt_o,
   output logic [CNT_W-1:0]  mispredict_cnt_o
);

   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_SQUASH = 1'b1;

   logic [0:0]        state_q, state_d;
   logic              v_q, v_d;
   logic              pred_q, pred_d;
   logic [ADDR_W-1:0] tgt_q, tgt_d;
   logic [ADDR_W-1:0] ft_q, ft_d;
   logic [CNT_W-1:0]  bcnt_q, bcnt_d;
   logic [CNT_W-1:0]  mcnt_q, mcnt_d;
   logic              resolve;
   logic              mispredict;

   // A branch resolves only from a valid slot in a non-stalled RUN cycle.
   assign resolve    = v_q && !stall_i && (state_q == ST_RUN);
   assign mispredict = resolve && (ex_taken_i != pred_q);

   assign branch_o         = resolve;
   assign update_o         = resolve && ex_taken_i;
   assign flush_o          = mispredict;
   assign redirect_valid_o = mispredict;
   assign redirect_pc_o    = mispredict ? (ex_taken_i ? tgt_q : ft_q) : '0;
   assign branch_cnt_o     = bcnt_q;
   assign mispredict_cnt_o = mcnt_q;

   always_comb begin
      // NOTE: every next-state signal gets a hold default first so no path leaves it unassigned (no latches).
      state_d = state_q;
      v_d     = v_q;
      pred_d  = pred_q;
      tgt_d   = tgt_q;
      ft_d    = ft_q;
      bcnt_d  = bcnt_q;
      mcnt_d  = mcnt_q;
      if (!stall_i) begin
         if (mispredict) begin
            v_d = 1'b0;
         end else begin
            v_d    = id_branch_i;
            pred_d = id_predict_i;
            tgt_d  = id_target_i;
            ft_d   = id_fallthru_i;
         end
         if (resolve && (bcnt_q != '1)) bcnt_d = bcnt_q + CNT_W'(1);
         if (mispredict && (mcnt_q != '1)) mcnt_d = mcnt_q + CNT_W'(1);
         case (state_q)
            ST_RUN:    state_d = mispredict ? ST_SQUASH : ST_RUN;
            ST_SQUASH: state_d = ST_RUN;
            default:   state_d = ST_RUN;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_RUN;
         v_q     <= 1'b0;
         bcnt_q  <= '0;
         mcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         v_q     <= v_d;
         bcnt_q  <= bcnt_d;
         mcnt_q  <= mcnt_d;
      end
   end

   // NOTE: slot payload is qualified by v_q, so it carries no reset.
   always_ff @(posedge clk_i) begin
      pred_q <= pred_d;
      tgt_q  <= tgt_d;
      ft_q   <= ft_d;
   end

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed test-plan cases plus random
// traffic compared every cycle against a pending-branch queue model.
module tb_branch_resolver;

   localparam int ADDR_W = 32;
   localparam int CNT_W  = 4;
   localparam int CMAX   = (1 << CNT_W) - 1;

   typedef struct {
      bit              pred;
      bit [ADDR_W-1:0] tgt;
      bit [ADDR_W-1:0] ft;
   } br_t;

   logic              clk = 1'b0;
   logic              rst_i, stall_i, id_branch_i, id_predict_i, ex_taken_i;
   logic [ADDR_W-1:0] id_target_i, id_fallthru_i;
   logic              branch_o, update_o, flush_o, redirect_valid_o;
   logic [ADDR_W-1:0] redirect_pc_o;
   logic [CNT_W-1:0]  branch_cnt_o, mispredict_cnt_o;

   int checks = 0;
   int errors = 0;

   // model state
   br_t pend[$];
   int  m_bcnt, m_mcnt;
   bit  in_squash;
   bit  cur_mis, cur_resolving;

   branch_resolver #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i),
      .id_branch_i(id_branch_i), .id_predict_i(id_predict_i),
      .id_target_i(id_target_i), .id_fallthru_i(id_fallthru_i),
      .ex_taken_i(ex_taken_i),
      .branch_o(branch_o), .update_o(update_o), .flush_o(flush_o),
      .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
      .branch_cnt_o(branch_cnt_o), .mispredict_cnt_o(mispredict_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle's inputs, then compare all outputs with the model mid-cycle.
   task automatic step(input bit rst, input bit stall, input bit idb, input bit idp,
                       input logic [ADDR_W-1:0] tgt, input logic [ADDR_W-1:0] ft,
                       input bit taken);
      logic [ADDR_W-1:0] exp_pc;
      rst_i = rst; stall_i = stall; id_branch_i = idb; id_predict_i = idp;
      id_target_i = tgt; id_fallthru_i = ft; ex_taken_i = taken;
      @(negedge clk);
      cur_resolving = (pend.size() != 0) && !stall;
      cur_mis       = cur_resolving && (taken != pend[0].pred);
      exp_pc        = '0;
      if (cur_mis) exp_pc = taken ? pend[0].tgt : pend[0].ft;
      check("branch_o", 64'(branch_o), 64'(cur_resolving));
      check("update_o", 64'(update_o), 64'(cur_resolving && taken));
      check("flush_o", 64'(flush_o), 64'(cur_mis));
      check("redirect_valid_o", 64'(redirect_valid_o), 64'(cur_mis));
      check("redirect_pc_o", 64'(redirect_pc_o), 64'(exp_pc));
      check("branch_cnt_o", 64'(branch_cnt_o), 64'(m_bcnt));
      check("mispredict_cnt_o", 64'(mispredict_cnt_o), 64'(m_mcnt));
   endtask

   // Advance through the rising edge and apply the rules to the model.
   task automatic tick();
      @(posedge clk);
      if (rst_i) begin
         pend.delete();
         m_bcnt = 0; m_mcnt = 0; in_squash = 0;
      end else if (!stall_i) begin
         if (cur_resolving) begin
            m_bcnt = (m_bcnt < CMAX) ? m_bcnt + 1 : CMAX;
            void'(pend.pop_front());
         end
         if (cur_mis) m_mcnt = (m_mcnt < CMAX) ? m_mcnt + 1 : CMAX;
         in_squash = cur_mis;
         if (!cur_mis && id_branch_i) begin
            br_t b;
            b.pred = id_predict_i; b.tgt = id_target_i; b.ft = id_fallthru_i;
            pend.push_back(b);
         end
      end
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, '0, '0, 0);
   endtask

   task automatic do_reset();
      step(1, 0, 0, 0, '0, '0, 0);
      tick();
   endtask

   initial begin
      int snap_b, snap_m;
      rst_i = 1; stall_i = 0; id_branch_i = 0; id_predict_i = 0;
      id_target_i = '0; id_fallthru_i = '0; ex_taken_i = 0;
      repeat (2) @(posedge clk);
      #1;
      pend.delete(); m_bcnt = 0; m_mcnt = 0; in_squash = 0;

      // reset values
      idle();
      check("rst_branch", 64'(branch_o), 0);
      check("rst_flush", 64'(flush_o), 0);
      check("rst_pc", 64'(redirect_pc_o), 0);
      check("rst_bcnt", 64'(branch_cnt_o), 0);
      check("rst_mcnt", 64'(mispredict_cnt_o), 0);
      tick();

      // correct prediction, taken
      step(0, 0, 1, 1, 32'h100, 32'h44, 0); tick();
      step(0, 0, 0, 0, '0, '0, 1);
      check("tp1_branch", 64'(branch_o), 1);
      check("tp1_update", 64'(update_o), 1);
      check("tp1_flush", 64'(flush_o), 0);
      tick();
      idle();
      check("tp1_bcnt", 64'(branch_cnt_o), 1);
      check("tp1_mcnt", 64'(mispredict_cnt_o), 0);
      tick();

      // mispredict not-taken -> taken, wrong-path ID branch discarded
      step(0, 0, 1, 0, 32'h200, 32'h84, 0); tick();
      step(0, 0, 1, 1, 32'h999, 32'h998, 1);
      check("tp2_rv", 64'(redirect_valid_o), 1);
      check("tp2_pc", 64'(redirect_pc_o), 64'h200);
      check("tp2_flush", 64'(flush_o), 1);
      tick();
      step(0, 0, 0, 0, '0, '0, 1);
      check("tp2_no_branch", 64'(branch_o), 0);
      check("tp2_flush_off", 64'(flush_o), 0);
      check("tp2_mcnt", 64'(mispredict_cnt_o), 1);
      check("tp2_bcnt", 64'(branch_cnt_o), 2);
      tick();

      // mispredict taken -> not-taken
      step(0, 0, 1, 1, 32'h300, 32'hC4, 0); tick();
      step(0, 0, 0, 0, '0, '0, 0);
      check("tp3_pc", 64'(redirect_pc_o), 64'hC4);
      check("tp3_update", 64'(update_o), 0);
      check("tp3_flush", 64'(flush_o), 1);
      tick();
      idle(); tick();

      // stall during resolve
      step(0, 0, 1, 0, 32'h400, 32'h104, 0); tick();
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0, '0, '0, 1);
         check("stall_branch", 64'(branch_o), 0);
         check("stall_flush", 64'(flush_o), 0);
         check("stall_bcnt", 64'(branch_cnt_o), 3);
         tick();
      end
      step(0, 0, 0, 0, '0, '0, 0);
      check("unstall_branch", 64'(branch_o), 1);
      tick();
      idle();
      check("unstall_once", 64'(branch_o), 0);
      check("unstall_bcnt", 64'(branch_cnt_o), 4);
      check("unstall_mcnt", 64'(mispredict_cnt_o), 2);
      tick();

      // saturation: 20 mispredicting branches
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step(0, 0, 1, 0, 32'(i * 16), 32'(i * 4), 0); tick();
         step(0, 0, 0, 0, '0, '0, 1); tick();
      end
      idle();
      check("sat_mcnt", 64'(mispredict_cnt_o), 15);
      check("sat_bcnt", 64'(branch_cnt_o), 15);
      tick();

      // reset mid-flight with a pending misprediction
      step(0, 0, 1, 0, 32'h500, 32'h144, 0); tick();
      step(1, 0, 1, 0, 32'h600, 32'h184, 1); tick();
      idle();
      check("rmf_branch", 64'(branch_o), 0);
      check("rmf_flush", 64'(flush_o), 0);
      check("rmf_rv", 64'(redirect_valid_o), 0);
      check("rmf_bcnt", 64'(branch_cnt_o), 0);
      check("rmf_mcnt", 64'(mispredict_cnt_o), 0);
      tick();
      idle();
      check("rmf_no_strobe", 64'(branch_o), 0);
      tick();

      // random traffic; the ID stage is a bubble while squashing
      for (int i = 0; i < 3000; i++) begin
         bit r, s, b;
         r = ($urandom_range(99) == 0);
         s = ($urandom_range(3) == 0);
         b = !in_squash && ($urandom_range(1) == 1);
         step(r, s, b, 1'($urandom), $urandom, $urandom, 1'($urandom));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
